// File: rtl/shapool_pkg.sv
// Shared definitions for the shapool host-side job controller.
// Holds frame sizes, result status codes and the controller state type.
package shapool_pkg;

   localparam int JOB_BYTES    = 47;
   localparam int JOB_BITS     = JOB_BYTES * 8;
   localparam int RESULT_BYTES = 5;

   localparam logic [7:0] STATUS_HALT      = 8'h00;
   localparam logic [7:0] STATUS_FOUND     = 8'h01;
   localparam logic [7:0] STATUS_EXHAUSTED = 8'h02;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      ARM    = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } state_e;

endpackage

// File: rtl/shapool_job_ctrl_if.sv
// Byte-stream bundle between a host and the shapool job controller.
//   rx_*  : job bytes into the controller (valid/ready)
//   tx_*  : result bytes out of the controller (valid/ready)
// master = host side, slave = controller side.
interface shapool_job_ctrl_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );
endinterface

// File: rtl/shapool_result_tx.sv
// Result frame serializer: on a start pulse latches {status, nonce32} and
// sends it as 5 bytes, status first then nonce MSB to LSB, over valid/ready.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   start          : load a new frame (only issued while idle)
//   status, nonce  : frame contents sampled on start
//   tx_data/valid  : outbound byte stream, registered
//   tx_ready       : sink accepts byte
//   done           : combinational, high on the handshake of the last byte
module shapool_result_tx
   import shapool_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [7:0]  status,
   input  logic [31:0] nonce,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   logic [RESULT_BYTES-1:0][7:0] frame_q, frame_d;
   logic [2:0]                   idx_q, idx_d;
   logic [7:0]                   tx_data_q, tx_data_d;
   logic                         tx_valid_q, tx_valid_d;
   logic                         tx_hs;

   assign tx_hs = tx_valid_q & tx_ready;
   // idx counts down to the final byte; index 0 holds nonce[7:0]
   assign done  = tx_hs && (idx_q == 3'd0);

   always_comb begin
      frame_d    = frame_q;
      idx_d      = idx_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      if (start) begin
         frame_d    = {status, nonce};
         idx_d      = 3'(RESULT_BYTES - 1);
         tx_data_d  = status;
         tx_valid_d = 1'b1;
      end else if (tx_hs) begin
         if (idx_q == 3'd0) begin
            tx_valid_d = 1'b0;
            tx_data_d  = 8'h00;
         end else begin
            idx_d     = idx_q - 3'd1;
            tx_data_d = frame_q[idx_q - 3'd1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         frame_q    <= '0;
         idx_q      <= '0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         frame_q    <= frame_d;
         idx_q      <= idx_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign tx_data  = tx_data_q;
   assign tx_valid = tx_valid_q;

endmodule

// File: rtl/shapool_job_ctrl.sv
// Host-side controller for the shapool mining pool. Assembles a 47-byte job
// in place, pulses the pool reset with the new job applied, watches the pool
// for a match, counter wrap or halt, and returns a 5-byte result frame.
// Ports:
//   clk, reset_n       : clock, synchronous active-low reset
//   bus (slave)        : rx job byte stream in, tx result byte stream out
//   halt               : abort partial load or running job
//   pool_reset_n       : registered reset to the pool
//   sha_state .. nonce_start_MSB : job parameters, change only in LOAD
//   pool_success/nonce : pool match flag and nonce counter
//   busy               : high in ARM and RUN
//
// state  | meaning
// -------+---------------------------------------------------------------
// LOAD   | accept job bytes; halt clears the byte count
// ARM    | one cycle, pool held in reset with the new job parameters
// RUN    | pool released; wait for success, counter wrap or halt
// REPORT | send the 5-byte result frame, then back to LOAD
module shapool_job_ctrl
   import shapool_pkg::*;
#(
   parameter int NONCE_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   shapool_job_ctrl_if.slave      bus,
   input  logic                   halt,
   output logic                   pool_reset_n,
   output logic [255:0]           sha_state,
   output logic [95:0]            message_head,
   output logic [15:0]            difficulty_bm,
   output logic [7:0]             nonce_start_MSB,
   input  logic                   pool_success,
   input  logic [NONCE_WIDTH-1:0] pool_nonce,
   output logic                   busy
);

   localparam logic [NONCE_WIDTH-1:0] NONCE_ONES = '1;

   state_e                    state_q, state_d;
   logic [5:0]                cnt_q, cnt_d;
   logic [JOB_BYTES-1:0][7:0] job_q, job_d;
   logic                      rx_ready_q, rx_ready_d;
   logic                      pool_reset_n_q, pool_reset_n_d;
   logic                      busy_q, busy_d;
   logic                      prev_all_ones_q, prev_all_ones_d;

   logic                      rx_hs;
   logic                      start;
   logic [7:0]                res_status;
   logic [31:0]               res_nonce;
   logic                      tx_done;
   logic [JOB_BITS-1:0]       job_flat;

   assign rx_hs = bus.rx_valid & rx_ready_q;

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      job_d           = job_q;
      prev_all_ones_d = (pool_nonce == NONCE_ONES);
      start           = 1'b0;
      res_status      = STATUS_HALT;
      res_nonce       = 32'(pool_nonce);

      case (state_q)
         LOAD: begin
            // halt beats a coincident handshake: the byte is dropped
            if (halt) begin
               cnt_d = '0;
            end else if (rx_hs) begin
               // byte k lands at packed index 46-k, i.e. bits [375-8k -: 8]
               job_d[6'(JOB_BYTES - 1) - cnt_q] = bus.rx_data;
               if (cnt_q == 6'(JOB_BYTES - 1)) begin
                  cnt_d   = '0;
                  state_d = ARM;
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end
         end
         ARM: begin
            prev_all_ones_d = 1'b0;
            state_d         = RUN;
         end
         RUN: begin
            if (pool_success) begin
               start      = 1'b1;
               res_status = STATUS_FOUND;
            end else if (prev_all_ones_q && (pool_nonce == '0)) begin
               // counter wrapped: the whole range was searched
               start      = 1'b1;
               res_status = STATUS_EXHAUSTED;
               res_nonce  = 32'(NONCE_ONES);
            end else if (halt) begin
               start = 1'b1;
            end
            if (start) state_d = REPORT;
         end
         REPORT: begin
            if (tx_done) state_d = LOAD;
         end
         default: state_d = LOAD;
      endcase

      rx_ready_d     = (state_d == LOAD);
      busy_d         = (state_d == ARM) || (state_d == RUN);
      // registered one cycle behind RUN entry so ARM plus the first RUN
      // cycle keep the pool in reset; drops right after the terminating edge
      pool_reset_n_d = (state_q == RUN) && !start;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q         <= LOAD;
         cnt_q           <= '0;
         job_q           <= '0;
         rx_ready_q      <= 1'b1;
         pool_reset_n_q  <= 1'b0;
         busy_q          <= 1'b0;
         prev_all_ones_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         cnt_q           <= cnt_d;
         job_q           <= job_d;
         rx_ready_q      <= rx_ready_d;
         pool_reset_n_q  <= pool_reset_n_d;
         busy_q          <= busy_d;
         prev_all_ones_q <= prev_all_ones_d;
      end
   end

   shapool_result_tx u_result_tx (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .status   (res_status),
      .nonce    (res_nonce),
      .tx_data  (bus.tx_data),
      .tx_valid (bus.tx_valid),
      .tx_ready (bus.tx_ready),
      .done     (tx_done)
   );

   assign job_flat        = job_q;
   assign sha_state       = job_flat[375:120];
   assign message_head    = job_flat[119:24];
   assign difficulty_bm   = job_flat[23:8];
   assign nonce_start_MSB = job_flat[7:0];
   assign bus.rx_ready    = rx_ready_q;
   assign pool_reset_n    = pool_reset_n_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_shapool_job_ctrl.sv
`timescale 1ns/1ps
module tb_shapool_job_ctrl;
   import shapool_pkg::*;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        halt = 1'b0;
   logic        pool_success = 1'b0;
   logic [31:0] nonce32 = '0;
   logic [8:0]  nonce9 = '0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic        tx_rdy = 1'b1;
   int          bp_mode = 0;
   int          pat_i = 0;

   int n_checks = 0;
   int n_fail = 0;

   shapool_job_ctrl_if bus32();
   shapool_job_ctrl_if bus9();

   assign bus32.rx_data  = rx_data;
   assign bus32.rx_valid = rx_valid;
   assign bus32.tx_ready = tx_rdy;
   assign bus9.rx_data   = rx_data;
   assign bus9.rx_valid  = rx_valid;
   assign bus9.tx_ready  = tx_rdy;

   logic         a_prst, a_busy, b_prst, b_busy;
   logic [255:0] a_sha, b_sha;
   logic [95:0]  a_mh, b_mh;
   logic [15:0]  a_diff, b_diff;
   logic [7:0]   a_nsm, b_nsm;

   shapool_job_ctrl #(.NONCE_WIDTH(32)) dut32 (
      .clk(clk), .reset_n(reset_n), .bus(bus32), .halt(halt),
      .pool_reset_n(a_prst), .sha_state(a_sha), .message_head(a_mh),
      .difficulty_bm(a_diff), .nonce_start_MSB(a_nsm),
      .pool_success(pool_success), .pool_nonce(nonce32), .busy(a_busy)
   );

   shapool_job_ctrl #(.NONCE_WIDTH(9)) dut9 (
      .clk(clk), .reset_n(reset_n), .bus(bus9), .halt(halt),
      .pool_reset_n(b_prst), .sha_state(b_sha), .message_head(b_mh),
      .difficulty_bm(b_diff), .nonce_start_MSB(b_nsm),
      .pool_success(pool_success), .pool_nonce(nonce9), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // tx_ready driver: always ready, random, or the repeating 1-0-0-1 pattern
   initial forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
         0: tx_rdy = 1'b1;
         1: tx_rdy = 1'($urandom_range(0, 1));
         default: begin
            tx_rdy = (pat_i == 0 || pat_i == 3);
            pat_i  = (pat_i + 1) % 4;
         end
      endcase
   end

   // tx monitors: collect handshaken bytes, check data holds while stalled
   logic [7:0] q32[$];
   logic [7:0] q9[$];
   logic       stall32 = 1'b0, stall9 = 1'b0;
   logic [7:0] hold32 = '0, hold9 = '0;

   always @(negedge clk) begin
      if (!reset_n) begin
         stall32 = 1'b0;
         stall9  = 1'b0;
      end else begin
         if (stall32) chk("tx_hold32", 256'({bus32.tx_valid, bus32.tx_data}), 256'({1'b1, hold32}));
         if (stall9)  chk("tx_hold9",  256'({bus9.tx_valid, bus9.tx_data}),   256'({1'b1, hold9}));
         if (bus32.tx_valid && tx_rdy) q32.push_back(bus32.tx_data);
         if (bus9.tx_valid && tx_rdy)  q9.push_back(bus9.tx_data);
         stall32 = bus32.tx_valid && !tx_rdy;
         hold32  = bus32.tx_data;
         stall9  = bus9.tx_valid && !tx_rdy;
         hold9   = bus9.tx_data;
      end
   end

   // job bytes and RUN-phase stimulus sequence (one entry per RUN cycle)
   logic [7:0]  jb[JOB_BYTES];
   logic [31:0] sn[$];
   bit          ss[$];
   bit          sh[$];

   // Reference: first RUN cycle where success, a wrap of the w-bit counter
   // (all-ones in the previous RUN cycle, zero now) or halt occurs.
   function automatic void predict(input int w, output int t, output logic [7:0] st,
                                   output logic [31:0] n);
      logic [31:0] mask, v, pv;
      mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      t = 9999; st = 8'h00; n = '0;
      for (int j = 0; j < sn.size(); j++) begin
         v  = sn[j] & mask;
         pv = (j > 0) ? (sn[j-1] & mask) : 32'd0;
         if (ss[j]) begin
            t = j; st = STATUS_FOUND; n = v; return;
         end
         if (j > 0 && pv == mask && v == 32'd0) begin
            t = j; st = STATUS_EXHAUSTED; n = mask; return;
         end
         if (sh[j]) begin
            t = j; st = STATUS_HALT; n = v; return;
         end
      end
   endfunction

   task automatic check_job_outputs(input string tag);
      logic [JOB_BITS-1:0] ef;
      ef = '0;
      for (int k = 0; k < JOB_BYTES; k++) ef = {ef[JOB_BITS-9:0], jb[k]};
      chk({tag, "_sha32"},  256'(a_sha),  256'(ef[375:120]));
      chk({tag, "_mh32"},   256'(a_mh),   256'(ef[119:24]));
      chk({tag, "_diff32"}, 256'(a_diff), 256'(ef[23:8]));
      chk({tag, "_nsm32"},  256'(a_nsm),  256'(ef[7:0]));
      chk({tag, "_sha9"},   256'(b_sha),  256'(ef[375:120]));
      chk({tag, "_nsm9"},   256'(b_nsm),  256'(ef[7:0]));
   endtask

   task automatic load_job(input bit gaps);
      for (int k = 0; k < JOB_BYTES; k++) begin
         if (gaps) begin
            while ($urandom_range(0, 3) == 0) begin
               rx_valid = 1'b0;
               step();
            end
         end
         rx_valid = 1'b1;
         rx_data  = jb[k];
         if (k == JOB_BYTES - 1) begin
            @(negedge clk);
            chk("pre_last_busy", 256'({a_busy, b_busy, bus32.rx_ready, bus9.rx_ready}), 256'(4'b0011));
         end
         step();
      end
      rx_valid = 1'b0;
      rx_data  = '0;
   endtask

   task automatic partial_halt(input int k, input bit coincident);
      for (int i = 0; i < k; i++) begin
         rx_valid = 1'b1;
         rx_data  = 8'($urandom());
         step();
      end
      halt     = 1'b1;
      rx_valid = coincident;
      rx_data  = 8'($urandom());
      step();
      halt     = 1'b0;
      rx_valid = 1'b0;
      @(negedge clk);
      chk("halt_load_idle", 256'({a_busy, b_busy, bus32.rx_ready, bus9.rx_ready}), 256'(4'b0011));
      step();
   endtask

   // Called right after the last job byte's handshake edge.
   task automatic run_job();
      int          t32, t9, n;
      logic [7:0]  st32, st9;
      logic [31:0] n32, n9;
      logic [39:0] f32, f9;
      bit          done;
      sh[sh.size()-1] = 1'b1;
      predict(32, t32, st32, n32);
      predict(9, t9, st9, n9);
      f32 = {st32, n32};
      f9  = {st9, n9};
      q32.delete();
      q9.delete();
      @(negedge clk);
      chk("arm_state", 256'({a_prst, b_prst, a_busy, b_busy, bus32.rx_ready, bus9.rx_ready}),
          256'(6'b001100));
      check_job_outputs("arm");
      step();
      for (int j = 0; j < sn.size(); j++) begin
         nonce32      = sn[j];
         nonce9       = sn[j][8:0];
         pool_success = ss[j];
         halt         = sh[j];
         @(negedge clk);
         chk("prst32", 256'(a_prst), 256'(j >= 1 && t32 >= j));
         chk("prst9",  256'(b_prst), 256'(j >= 1 && t9 >= j));
         step();
      end
      pool_success = 1'b0;
      halt         = 1'b0;
      done = 1'b0;
      n = 0;
      while (!done && n < 400) begin
         @(negedge clk);
         done = bus32.rx_ready && !bus32.tx_valid && bus9.rx_ready && !bus9.tx_valid;
         if (!done) step();
         n++;
      end
      chk("report_done", 256'(done), 256'(1'b1));
      chk("frame_len32", 256'(q32.size()), 256'(RESULT_BYTES));
      chk("frame_len9",  256'(q9.size()),  256'(RESULT_BYTES));
      for (int i = 0; i < RESULT_BYTES; i++) begin
         chk("frame32", (i < q32.size()) ? 256'(q32[i]) : 256'h100, 256'(f32[39-8*i -: 8]));
         chk("frame9",  (i < q9.size())  ? 256'(q9[i])  : 256'h100, 256'(f9[39-8*i -: 8]));
      end
      chk("post_idle", 256'({a_prst, b_prst, a_busy, b_busy}), 256'(4'b0000));
      check_job_outputs("post");
      step();
   endtask

   task automatic clear_seq();
      sn.delete(); ss.delete(); sh.delete();
   endtask

   task automatic add(input logic [31:0] v, input bit s, input bit h);
      sn.push_back(v); ss.push_back(s); sh.push_back(h);
   endtask

   task automatic random_job_bytes();
      for (int k = 0; k < JOB_BYTES; k++) jb[k] = 8'($urandom());
   endtask

   task automatic gen_seq();
      int          mode, len;
      logic [31:0] v;
      clear_seq();
      mode = $urandom_range(0, 2);
      len  = $urandom_range(4, 24);
      if (mode == 1) v = 32'hFFFF_FFFF - 32'($urandom_range(0, 8));
      else           v = ($urandom() & 32'hFFFF_FE00) | (32'h1F4 + 32'($urandom_range(0, 10)));
      for (int j = 0; j < len; j++) begin
         if (mode == 0) v = $urandom();
         add(v, $urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0);
         if (mode != 0 && $urandom_range(0, 5) != 0) v = v + 32'd1;
      end
   endtask

   initial begin
      repeat (3) step();
      @(negedge clk);
      chk("rst_rx_ready", 256'({bus32.rx_ready, bus9.rx_ready}), 256'(2'b11));
      chk("rst_tx", 256'({bus32.tx_valid, bus32.tx_data, bus9.tx_valid, bus9.tx_data}), 256'(0));
      chk("rst_prst_busy", 256'({a_prst, b_prst, a_busy, b_busy}), 256'(0));
      chk("rst_job", a_sha ^ {a_mh, a_diff, a_nsm, 136'(0)}, 256'(0));
      reset_n = 1'b1;
      step();

      // job 0..46, success at 0x00C0FFEE
      for (int k = 0; k < JOB_BYTES; k++) jb[k] = 8'(k);
      load_job(1'b0);
      chk("d_sha_top", 256'(a_sha[255:248]), 256'(8'h00));
      chk("d_nsm", 256'(a_nsm), 256'(8'h2E));
      chk("d_diff", 256'(a_diff), 256'(16'h2C2D));
      clear_seq();
      add(32'h00C0_FFEE, 0, 0); add(32'h00C0_FFEE, 0, 0); add(32'h00C0_FFEE, 1, 0);
      run_job();

      // exhaustion at 0x1FE, 0x1FF, 0x000 (and the 32-bit counter too)
      random_job_bytes();
      load_job(1'b1);
      clear_seq();
      add(32'hFFFF_FFFE, 0, 0); add(32'hFFFF_FFFF, 0, 0); add(32'h0000_0000, 0, 0);
      run_job();

      // success coincident with wrap
      random_job_bytes();
      load_job(1'b0);
      clear_seq();
      add(32'hFFFF_FFFE, 0, 0); add(32'hFFFF_FFFF, 0, 0); add(32'h0000_0000, 1, 0);
      run_job();

      // halt after 20 bytes, then a full load; halt in RUN at 0x12345678
      partial_halt(20, 1'b0);
      random_job_bytes();
      load_job(1'b0);
      clear_seq();
      add(32'h1234_5678, 0, 1);
      run_job();

      // halt coincident with byte 46 discards it
      partial_halt(46, 1'b1);
      random_job_bytes();
      load_job(1'b1);
      clear_seq();
      add(32'h0000_01FF, 0, 0); add(32'hDEAD_BEEF, 1, 0);
      bp_mode = 2;
      pat_i   = 0;
      run_job();

      // randomized jobs
      for (int r = 0; r < 14; r++) begin
         bp_mode = $urandom_range(0, 2);
         if ($urandom_range(0, 3) == 0) partial_halt($urandom_range(0, 46), 1'($urandom_range(0, 1)));
         random_job_bytes();
         load_job(1'($urandom_range(0, 1)));
         gen_seq();
         run_job();
      end

      // reset in REPORT after two bytes sent
      bp_mode = 0;
      random_job_bytes();
      load_job(1'b0);
      q32.delete();
      q9.delete();
      step();
      nonce32      = 32'hA5A5_A5A5;
      nonce9       = 9'h1A5;
      pool_success = 1'b1;
      step();
      pool_success = 1'b0;
      step();
      step();
      reset_n = 1'b0;
      step();
      @(negedge clk);
      chk("mid_rst_sent", 256'(q32.size()), 256'(2));
      chk("mid_rst_tx", 256'({bus32.tx_valid, bus9.tx_valid}), 256'(0));
      chk("mid_rst_ctrl", 256'({bus32.rx_ready, a_prst, a_busy, b_prst}), 256'(4'b1000));
      chk("mid_rst_job", 256'({a_sha[255:0] != 0, a_mh != 0, a_diff != 0, a_nsm != 0, b_sha != 0}), 256'(0));
      reset_n = 1'b1;
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
